// File: rtl/video_dnn_colorizer.sv
// video_dnn_colorizer: tints confidently classified pixels with a per-class
// palette colour (replace or 50% blend) on a 2-stage AXI4-Stream pipeline.
// Optional per-frame class histogram: define VIDEO_DNN_COLORIZER_HISTOGRAM_EN.
module video_dnn_colorizer #(
   parameter int unsigned TUSER_WIDTH   = 1,
   parameter int unsigned TNUMBER_WIDTH = 4,
   parameter int unsigned TCOUNT_WIDTH  = 4,
   parameter int unsigned TDATA_WIDTH   = 24,
   parameter int unsigned NUM_CLASS     = 10,
   parameter int unsigned HIST_WIDTH    = 20
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [1:0]                      param_mode,
   input  logic [TCOUNT_WIDTH-1:0]         param_th,
   input  logic [TUSER_WIDTH-1:0]          s_axi4s_tuser,
   input  logic                            s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0]        s_axi4s_tnumber,
   input  logic [TCOUNT_WIDTH-1:0]         s_axi4s_tcount,
   input  logic [TDATA_WIDTH-1:0]          s_axi4s_tdata,
   input  logic                            s_axi4s_tvalid,
   output logic                            s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]          m_axi4s_tuser,
   output logic                            m_axi4s_tlast,
   output logic [TDATA_WIDTH-1:0]          m_axi4s_tdata,
   output logic                            m_axi4s_tvalid,
   input  logic                            m_axi4s_tready,
   output logic [NUM_CLASS*HIST_WIDTH-1:0] hist_count,
   output logic                            hist_valid
);

   localparam int unsigned CH_W   = 8;
   localparam int unsigned NUM_CH = TDATA_WIDTH / CH_W;

   // Fixed class palette; unknown classes map to black (never used, they never qualify).
   function automatic logic [TDATA_WIDTH-1:0] palette(input logic [TNUMBER_WIDTH-1:0] n);
      logic [23:0] c;
      case (32'(n))
         32'd0:   c = 24'hFF0000;
         32'd1:   c = 24'hFF8000;
         32'd2:   c = 24'hFFFF00;
         32'd3:   c = 24'h80FF00;
         32'd4:   c = 24'h00FF00;
         32'd5:   c = 24'h00FFFF;
         32'd6:   c = 24'h0080FF;
         32'd7:   c = 24'h0000FF;
         32'd8:   c = 24'h8000FF;
         32'd9:   c = 24'hFF00FF;
         default: c = 24'h000000;
      endcase
      return TDATA_WIDTH'(c);
   endfunction

   logic cke;
   logic accept;
   logic qualify;

   assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
   assign s_axi4s_tready = cke;
   assign accept         = s_axi4s_tvalid && cke;
   assign qualify        = (s_axi4s_tcount >= param_th) && (32'(s_axi4s_tnumber) < NUM_CLASS);

   logic                     s1_valid;
   logic [TUSER_WIDTH-1:0]   s1_user;
   logic                     s1_last;
   logic [TDATA_WIDTH-1:0]   s1_data;
   logic [TDATA_WIDTH-1:0]   s1_color;
   logic                     s1_qual;
   logic [1:0]               s1_mode;
   logic [TDATA_WIDTH-1:0]   overlay;

   // Stage 1: capture the beat, its palette colour, qualification and mode.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid <= 1'b0;
         s1_user  <= '0;
         s1_last  <= 1'b0;
         s1_data  <= '0;
         s1_color <= '0;
         s1_qual  <= 1'b0;
         s1_mode  <= 2'd0;
      end else if (cke) begin
         s1_valid <= s_axi4s_tvalid;
         s1_user  <= s_axi4s_tuser;
         s1_last  <= s_axi4s_tlast;
         s1_data  <= s_axi4s_tdata;
         s1_color <= palette(s_axi4s_tnumber);
         s1_qual  <= qualify;
         s1_mode  <= param_mode;
      end
   end

   // Overlay select: pass, replace, or per-channel average of pixel and colour.
   always_comb begin
      logic [CH_W:0] sum;
      sum     = '0;
      overlay = s1_data;
      if (s1_qual) begin
         case (s1_mode)
            2'd1: overlay = s1_color;
            2'd2: begin
               for (int unsigned c = 0; c < NUM_CH; c++) begin
                  sum = {1'b0, s1_data[c*CH_W +: CH_W]} + {1'b0, s1_color[c*CH_W +: CH_W]};
                  overlay[c*CH_W +: CH_W] = sum[CH_W:1];
               end
            end
            default: overlay = s1_data;
         endcase
      end
   end

   // Stage 2: output register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axi4s_tvalid <= 1'b0;
         m_axi4s_tuser  <= '0;
         m_axi4s_tlast  <= 1'b0;
         m_axi4s_tdata  <= '0;
      end else if (cke) begin
         m_axi4s_tvalid <= s1_valid;
         m_axi4s_tuser  <= s1_user;
         m_axi4s_tlast  <= s1_last;
         m_axi4s_tdata  <= overlay;
      end
   end

`ifdef VIDEO_DNN_COLORIZER_HISTOGRAM_EN
   logic [HIST_WIDTH-1:0] cnt [NUM_CLASS];
   logic                  first_frame;

   // Per-frame class histogram; latched and restarted at each accepted start-of-frame.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned k = 0; k < NUM_CLASS; k++) cnt[k] <= '0;
         hist_count  <= '0;
         hist_valid  <= 1'b0;
         first_frame <= 1'b1;
      end else begin
         hist_valid <= 1'b0;
         if (accept) begin
            if (s_axi4s_tuser[0]) begin
               if (!first_frame) begin
                  hist_valid <= 1'b1;
                  for (int unsigned k = 0; k < NUM_CLASS; k++)
                     hist_count[k*HIST_WIDTH +: HIST_WIDTH] <= cnt[k];
               end
               first_frame <= 1'b0;
            end
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
               if (s_axi4s_tuser[0])
                  cnt[k] <= (qualify && 32'(s_axi4s_tnumber) == k) ? HIST_WIDTH'(1) : '0;
               else if (qualify && 32'(s_axi4s_tnumber) == k && cnt[k] != '1)
                  cnt[k] <= cnt[k] + HIST_WIDTH'(1);
            end
         end
      end
   end
`else
   assign hist_count = '0;
   assign hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_dnn_colorizer.sv
// Directed bench for video_dnn_colorizer: overlay modes, thresholds, stall,
// mid-stream reset and (when VIDEO_DNN_COLORIZER_HISTOGRAM_EN) histogram pulse.
module tb_video_dnn_colorizer;

   localparam int unsigned HW = 20;
   localparam int unsigned NC = 10;
   localparam int unsigned HB = NC*HW;
   localparam int unsigned NV = 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    mode;
   logic [3:0]    th;
   logic [0:0]    s_user;
   logic          s_last;
   logic [3:0]    s_num;
   logic [3:0]    s_cnt;
   logic [23:0]   s_data;
   logic          s_valid;
   logic          s_ready;
   logic [0:0]    m_user;
   logic          m_last;
   logic [23:0]   m_data;
   logic          m_valid;
   logic          m_ready;
   logic [HB-1:0] h_count;
   logic          h_valid;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   video_dnn_colorizer dut (
      .aclk            (clk),
      .aresetn         (rst_n),
      .param_mode      (mode),
      .param_th        (th),
      .s_axi4s_tuser   (s_user),
      .s_axi4s_tlast   (s_last),
      .s_axi4s_tnumber (s_num),
      .s_axi4s_tcount  (s_cnt),
      .s_axi4s_tdata   (s_data),
      .s_axi4s_tvalid  (s_valid),
      .s_axi4s_tready  (s_ready),
      .m_axi4s_tuser   (m_user),
      .m_axi4s_tlast   (m_last),
      .m_axi4s_tdata   (m_data),
      .m_axi4s_tvalid  (m_valid),
      .m_axi4s_tready  (m_ready),
      .hist_count      (h_count),
      .hist_valid      (h_valid)
   );

   task automatic chk(input string tag, input logic [HB-1:0] got, input logic [HB-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] md, input logic [3:0] t,
                        input logic u, input logic l, input logic [3:0] num,
                        input logic [3:0] cnt, input logic [23:0] d);
      s_valid = v;
      mode    = md;
      th      = t;
      s_user  = u;
      s_last  = l;
      s_num   = num;
      s_cnt   = cnt;
      s_data  = d;
   endtask

   // mode, th, tuser, tlast, tnumber, tcount, tdata, expected tdata
   int          v_mode [NV] = '{1, 2, 2, 1, 3, 0, 1, 1, 2};
   int          v_th   [NV] = '{5, 5, 1, 1, 1, 1, 0, 15, 2};
   logic        v_user [NV] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
   logic        v_last [NV] = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
   int          v_num  [NV] = '{3, 3, 0, 12, 5, 9, 9, 15, 6};
   int          v_cnt  [NV] = '{5, 4, 15, 15, 9, 1, 0, 15, 2};
   logic [23:0] v_data [NV] = '{24'h123456, 24'h123456, 24'h00FF80, 24'hABCDEF, 24'h112233,
                                24'h445566, 24'h102030, 24'h0A0B0C, 24'h204060};
   logic [23:0] v_exp  [NV] = '{24'h80FF00, 24'h123456, 24'h7F7F40, 24'hABCDEF, 24'h112233,
                                24'h445566, 24'hFF00FF, 24'h0A0B0C, 24'h1060AF};

   initial begin
      logic [HB-1:0] exp_h;
      logic          exp_pulse;
`ifdef VIDEO_DNN_COLORIZER_HISTOGRAM_EN
      exp_pulse = 1'b1;
      exp_h     = '0;
      exp_h[7*HW +: HW] = HW'(3);
`else
      exp_pulse = 1'b0;
      exp_h     = '0;
`endif
      rst_n   = 1'b0;
      m_ready = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 24'h0);
      step();
      step();
      chk("rst_tvalid", HB'(m_valid), '0);
      chk("rst_tdata",  HB'(m_data),  '0);
      chk("rst_tuser",  HB'(m_user),  '0);
      chk("rst_tlast",  HB'(m_last),  '0);
      chk("rst_hcount", h_count,      '0);
      chk("rst_hvalid", HB'(h_valid), '0);
      chk("rst_tready", HB'(s_ready), HB'(1));
      rst_n = 1'b1;
      step();

      // back-to-back vectors; result i-1 visible after step i
      for (int i = 0; i <= int'(NV); i++) begin
         if (i < int'(NV))
            drive(1, 2'(v_mode[i]), 4'(v_th[i]), v_user[i], v_last[i],
                  4'(v_num[i]), 4'(v_cnt[i]), v_data[i]);
         else
            drive(0, 0, 0, 0, 0, 0, 0, 24'h0);
         step();
         if (i == 0) begin
            chk("lat_first", HB'(m_valid), '0);
         end else begin
            chk($sformatf("v%0d_tvalid", i-1), HB'(m_valid), HB'(1));
            chk($sformatf("v%0d_tdata", i-1),  HB'(m_data),  HB'(v_exp[i-1]));
            chk($sformatf("v%0d_tuser", i-1),  HB'(m_user),  HB'(v_user[i-1]));
            chk($sformatf("v%0d_tlast", i-1),  HB'(m_last),  HB'(v_last[i-1]));
         end
      end
      step();
      chk("drain_tvalid", HB'(m_valid), '0);

      // stall: two beats in flight, output held for 3 cycles
      m_ready = 1'b0;
      drive(1, 1, 1, 0, 0, 1, 3, 24'h000000);
      step();
      drive(1, 1, 1, 0, 0, 2, 3, 24'h000000);
      step();
      drive(1, 1, 1, 0, 1, 4, 3, 24'h000000);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall%0d_tready", k), HB'(s_ready), '0);
         chk($sformatf("stall%0d_tvalid", k), HB'(m_valid), HB'(1));
         chk($sformatf("stall%0d_tdata", k),  HB'(m_data),  HB'(24'hFF8000));
         step();
      end
      chk("stall_end_tdata", HB'(m_data), HB'(24'hFF8000));
      m_ready = 1'b1;
      #1;
      chk("resume_tready", HB'(s_ready), HB'(1));
      step();
      chk("resume_q_tdata", HB'(m_data), HB'(24'hFFFF00));
      chk("resume_q_tvalid", HB'(m_valid), HB'(1));
      drive(0, 0, 0, 0, 0, 0, 0, 24'h0);
      step();
      chk("resume_r_tdata", HB'(m_data), HB'(24'h00FF00));
      chk("resume_r_tlast", HB'(m_last), HB'(1));
      step();
      chk("resume_empty", HB'(m_valid), '0);

      // reset with a beat on the output
      drive(1, 1, 1, 1, 1, 2, 3, 24'h0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 24'h0);
      step();
      chk("prerst_tvalid", HB'(m_valid), HB'(1));
      rst_n = 1'b0;
      step();
      chk("midrst_tvalid", HB'(m_valid), '0);
      chk("midrst_tdata",  HB'(m_data),  '0);
      chk("midrst_tuser",  HB'(m_user),  '0);
      chk("midrst_tlast",  HB'(m_last),  '0);
      rst_n = 1'b1;
      drive(1, 1, 1, 0, 1, 8, 4, 24'h555555);
      step();
      chk("postrst_lat1", HB'(m_valid), '0);
      drive(0, 0, 0, 0, 0, 0, 0, 24'h0);
      step();
      chk("postrst_tvalid", HB'(m_valid), HB'(1));
      chk("postrst_tdata",  HB'(m_data),  HB'(24'h8000FF));
      step();
      chk("postrst_empty", HB'(m_valid), '0);

      // frame A: class 7 qualified x3, one below threshold
      drive(1, 1, 5, 1, 0, 7, 5, 24'h0);
      step();
      chk("hA0_hvalid", HB'(h_valid), '0);
      drive(1, 1, 5, 0, 0, 7, 9, 24'h0);
      step();
      chk("hA1_hvalid", HB'(h_valid), '0);
      drive(1, 1, 5, 0, 0, 7, 4, 24'h0);
      step();
      chk("hA2_hvalid", HB'(h_valid), '0);
      drive(1, 1, 5, 0, 1, 7, 15, 24'h0);
      step();
      chk("hA3_hvalid", HB'(h_valid), '0);
      chk("hA_hcount",  h_count,      '0);
      // frame B start latches frame A
      drive(1, 1, 5, 1, 0, 2, 6, 24'h0);
      step();
      chk("hB_hvalid", HB'(h_valid), HB'(exp_pulse));
      chk("hB_hcount", h_count,      exp_h);
      drive(0, 0, 0, 0, 0, 0, 0, 24'h0);
      step();
      chk("hB_pulse_end", HB'(h_valid), '0);
      chk("hB_hold",      h_count,      exp_h);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
